// File: rtl/mem_arb_pkg.sv
// Shared constants for the instruction/data memory port arbiter: FSM encoding and default sizes.
package mem_arb_pkg;

    localparam int ADDR_W_DEF   = 32;
    localparam int DATA_W_DEF   = 32;
    localparam int MAX_WAIT_DEF = 255;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Any state other than IDLE has a memory access outstanding.
    function automatic logic is_busy(input logic [1:0] st);
        return st != ST_IDLE;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-ported memory bus: the arbiter drives the request side, the memory answers with ack/rdata.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_we, mem_adr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_adr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/wait_timer.sv
// Saturating wait counter; expired flags the MAX_WAIT-th enabled cycle since the last clear.
module wait_timer #(
    parameter int MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int                CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one variable-latency memory; data wins ties, flushed
// fetches are drained silently, and stuck accesses are aborted after MAX_WAIT cycles.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_adr,
    input  logic              if_flush,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_adr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,

    output logic              stall,
    output logic              bus_err,

    mem_port_arbiter_if.master mem
);

    logic [1:0]        state_q,     state_d;
    logic              mem_req_q,   mem_req_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_adr_q,   mem_adr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_done_q,   if_done_d;
    logic              d_done_q,    d_done_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              bus_err_q,   bus_err_d;

    logic grant;
    logic timer_en;
    logic timed_out;

    assign timer_en = is_busy(state_q);

    wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (grant),
        .en      (timer_en),
        .expired (timed_out)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_adr_d   = mem_adr_q;
        mem_wdata_d = mem_wdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        bus_err_d   = bus_err_q;
        grant       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The done cycle is a bubble: the requester still holds req for one more cycle.
                if (!if_done_q && !d_done_q) begin
                    if (d_req) begin
                        grant       = 1'b1;
                        state_d     = ST_DATA;
                        mem_req_d   = 1'b1;
                        mem_we_d    = d_we;
                        mem_adr_d   = d_adr;
                        mem_wdata_d = d_wdata;
                    end else if (if_req && !if_flush) begin
                        grant       = 1'b1;
                        state_d     = ST_FETCH;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_adr_d   = if_adr;
                        mem_wdata_d = '0;
                    end
                end
            end

            ST_FETCH: begin
                if (if_flush) begin
                    // An ack in the flush cycle already finished the access, so skip DRAIN.
                    if (mem.mem_ack) begin
                        state_d   = ST_IDLE;
                        mem_req_d = 1'b0;
                    end else if (timed_out) begin
                        state_d   = ST_IDLE;
                        mem_req_d = 1'b0;
                        bus_err_d = 1'b1;
                    end else begin
                        state_d   = ST_DRAIN;
                    end
                end else if (mem.mem_ack) begin
                    state_d    = ST_IDLE;
                    mem_req_d  = 1'b0;
                    if_done_d  = 1'b1;
                    if_rdata_d = mem.mem_rdata;
                end else if (timed_out) begin
                    state_d    = ST_IDLE;
                    mem_req_d  = 1'b0;
                    bus_err_d  = 1'b1;
                    if_done_d  = 1'b1;
                    if_rdata_d = '0;
                end
            end

            ST_DATA: begin
                if (mem.mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    d_done_d  = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = mem.mem_rdata;
                    end
                end else if (timed_out) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    bus_err_d = 1'b1;
                    d_done_d  = 1'b1;
                    d_rdata_d = '0;
                end
            end

            ST_DRAIN: begin
                if (mem.mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                end else if (timed_out) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_adr_q   <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_adr   = mem_adr_q;
    assign mem.mem_wdata = mem_wdata_q;

    assign if_done  = if_done_q;
    assign d_done   = d_done_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign bus_err  = bus_err_q;

    // Gated by reset so the pipeline is released the moment reset asserts.
    assign stall = rst & ((d_req & ~d_done_q)
                        | (if_req & ~if_flush & ~if_done_q)
                        | (state_q == ST_DRAIN));

endmodule
